// File: rtl/vm2002_change_dispenser.sv
// vm2002_change_dispenser: greedy coin change payout with inventory tracking and saturating refill
module vm2002_change_dispenser #(
  parameter int COUNT_W      = 8,
  parameter int AMT_W        = 8,
  parameter int INIT_NICKEL  = 16,
  parameter int INIT_DIME    = 16,
  parameter int INIT_QUARTER = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               change_req,
  input  logic [AMT_W-1:0]   change_amt,
  output logic               busy,
  output logic               coin_valid,
  output logic [1:0]         coin_type,
  input  logic               coin_ready,
  output logic               done,
  output logic               short,
  output logic [AMT_W-1:0]   remaining,
  input  logic               refill_en,
  input  logic [1:0]         refill_type,
  input  logic [COUNT_W-1:0] refill_cnt,
  output logic [COUNT_W-1:0] inv_nickel,
  output logic [COUNT_W-1:0] inv_dime,
  output logic [COUNT_W-1:0] inv_quarter
);
  localparam logic [1:0] IDLE = 2'd0, SELECT = 2'd1, DISPENSE = 2'd2, DONE = 2'd3;
  logic [1:0]         r_state, r_type;
  logic [AMT_W-1:0]   r_rem, r_remaining;
  logic               r_short;
  logic [COUNT_W-1:0] r_inv [3];
  logic [COUNT_W-1:0] w_inv_nxt [3];
  logic               w_hs, w_q, w_d, w_n;
  logic [AMT_W-1:0]   w_rem_dec;
  assign busy        = r_state != IDLE;
  assign coin_valid  = r_state == DISPENSE;
  assign done        = r_state == DONE;
  assign coin_type   = r_type;
  assign short       = r_short;
  assign remaining   = done ? r_rem : r_remaining;
  assign inv_nickel  = r_inv[0];
  assign inv_dime    = r_inv[1];
  assign inv_quarter = r_inv[2];
  assign w_hs        = coin_valid & coin_ready;
  assign w_rem_dec   = r_rem - (r_type == 2'd2 ? AMT_W'(5) : r_type == 2'd1 ? AMT_W'(2) : AMT_W'(1));
  assign w_q         = r_rem >= AMT_W'(5) && r_inv[2] != '0;
  assign w_d         = r_rem >= AMT_W'(2) && r_inv[1] != '0;
  assign w_n         = r_inv[0] != '0;
  // refill saturates first, then the same-cycle eject is taken off
  for (genvar i = 0; i < 3; i++) begin : g_inv
    logic [COUNT_W:0] w_sum;
    assign w_sum = {1'b0, r_inv[i]} + {1'b0, (refill_en && refill_type == 2'(i)) ? refill_cnt : '0};
    assign w_inv_nxt[i] = (w_sum[COUNT_W] ? '1 : w_sum[COUNT_W-1:0]) - COUNT_W'(w_hs && r_type == 2'(i));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_type      <= 2'd0;
      r_rem       <= '0;
      r_remaining <= '0;
      r_short     <= 1'b0;
      r_inv[0]    <= COUNT_W'(INIT_NICKEL);
      r_inv[1]    <= COUNT_W'(INIT_DIME);
      r_inv[2]    <= COUNT_W'(INIT_QUARTER);
    end else begin
      for (int k = 0; k < 3; k++) r_inv[k] <= w_inv_nxt[k];
      case (r_state)
        IDLE: if (change_req) begin
          r_rem   <= change_amt;
          r_short <= 1'b0;
          r_state <= change_amt == '0 ? DONE : SELECT;
        end
        SELECT: begin
          r_type  <= w_q ? 2'd2 : w_d ? 2'd1 : 2'd0;
          r_short <= !(w_q || w_d || w_n);
          r_state <= (w_q || w_d || w_n) ? DISPENSE : DONE;
        end
        DISPENSE: if (coin_ready) begin
          r_rem   <= w_rem_dec;
          r_state <= w_rem_dec == '0 ? DONE : SELECT;
        end
        default: begin
          r_remaining <= r_rem;
          r_state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/vm2002_change_dispenser.md
Name: vm2002_change_dispenser

Overview:
- Coin-output end of the vm2002 coin interface; the coin acceptor takes coins in, this block pays change out in the same coins_t encoding (NICKEL=0, DIME=1, QUARTER=2, ILLEGALCOIN=3).
- The vend controller issues a change amount in nickel units. The block pays it out greedily from its nickel, dime and quarter inventories, one coin per valid/ready handshake with the coin-eject mechanism.
- It tracks inventory (decrement on eject, saturating refill) and reports done or short-change.

Parameters:
- COUNT_W, 8, width of each coin inventory counter.
- AMT_W, 8, width of the change amount (units of $0.05).
- INIT_NICKEL, 16, nickel inventory after reset.
- INIT_DIME, 16, dime inventory after reset.
- INIT_QUARTER, 16, quarter inventory after reset.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- change_req  in  1  start request; sampled only in IDLE.
- change_amt  in  AMT_W  amount owed in nickel units; latched with change_req.
- busy  out  1  high in every state except IDLE.
- coin_valid  out  1  a coin is presented for ejection.
- coin_type  out  2  coins_t code of the presented coin.
- coin_ready  in  1  eject mechanism accepts the presented coin.
- done  out  1  one-cycle pulse at the end of a transaction.
- short  out  1  valid with done; high when change could not be completed.
- remaining  out  AMT_W  unpaid amount; updated at done and held until the next request.
- refill_en  in  1  add coins to inventory this cycle.
- refill_type  in  2  coins_t code of the refilled coin.
- refill_cnt  in  COUNT_W  number of coins added.
- inv_nickel, inv_dime, inv_quarter  out  COUNT_W each  current inventories.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - busy, coin_valid, done, short = 0; coin_type = NICKEL; remaining = 0; internal rem = 0.
  - Inventories = INIT_*.
  - A reset in the middle of a transaction aborts it: no done pulse, and the partial payout is not recorded.
- Coin values in nickel units: QUARTER=5, DIME=2, NICKEL=1.
- States: IDLE, SELECT, DISPENSE, DONE.
- IDLE:
  - change_req=1 latches change_amt into rem.
  - If amt=0, go to DONE with short=0; otherwise go to SELECT.
  - change_req is ignored in every other state.
- SELECT (one cycle), greedy choice using registered inventories:
  - QUARTER if rem>=5 and inv_quarter>0;
  - else DIME if rem>=2 and inv_dime>0;
  - else NICKEL if inv_nickel>0 (rem>=1 always holds here);
  - else go to DONE with short=1.
  - When a coin is chosen, register coin_type and go to DISPENSE.
- DISPENSE:
  - coin_valid=1; coin_type is held stable until handshake, with unbounded backpressure allowed.
  - On coin_valid & coin_ready: rem -= value, that coin's inventory -= 1, coin_valid drops the next cycle.
  - Next state is DONE if the new rem = 0, else SELECT.
- DONE (one cycle):
  - done=1; short as decided; remaining = rem; then IDLE.
- Latency:
  - Request accepted at edge k; coin_valid first high in cycle k+2.
  - With coin_ready held high, each coin costs 2 cycles.
  - done is high in the cycle after the final handshake.
- Arithmetic:
  - rem never underflows; greedy only selects a coin whose value is <= rem.
- Refill:
  - Accepted in any state, including during a transaction.
  - Adds refill_cnt to the selected inventory, saturating at 2^COUNT_W-1.
  - refill_type=ILLEGALCOIN is ignored.
- Refill in the same cycle as a decrement of the same type: result = sat(inv + refill_cnt) - 1.
- Inventory visibility: a refill becomes visible to SELECT from the next cycle onward.
- Short change:
  - Greedy is not backtracked. A short result leaves rem unpaid, and the coins already ejected stay ejected.

Test Plan:
1. Defaults, amt=30, coin_ready=1 -> six QUARTER handshakes, 2 cycles apart; done with short=0, remaining=0; inv_quarter=10.
2. amt=8 -> ejects QUARTER, DIME, NICKEL in that order; inventories 15/15/15; done, short=0.
3. INIT_NICKEL=0, amt=3 -> one DIME, then done with short=1, remaining=1; inv_dime=15.
4. amt=5 with coin_ready low for 5 cycles after coin_valid rises -> coin_valid and coin_type=QUARTER stay stable with no inventory change; ready high -> inv_quarter=15 and done the following cycle.
5. Two refills:
   - INIT_QUARTER=250, refill QUARTER cnt=10 in the same cycle as a quarter handshake -> inv_quarter=254.
   - refill_type=ILLEGALCOIN -> no inventory changes.
6. Edge cases:
   - amt=0 -> done in the cycle after the request, short=0, no coin_valid.
   - rst_n low during DISPENSE -> coin_valid=0 and busy=0 immediately, inventories = INIT_*, and no done pulse.
